// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single write port (w / select_register / s) of the 16 x N
//   general register file among three requesters:
//     0 = ALU writeback, 1 = memory load return, 2 = immediate/move unit.
//   Round-robin arbitration with an optional burst lock (8-grant cap) and a
//   valid/ready handshake per requester. Write-port outputs are registered,
//   so a write appears one cycle after its transfer.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall                    datapath hold: no grants, all bookkeeping frozen
//   reqX_valid/addr/data/lock  request, destination, data, burst lock
//   reqX_ready               grant (combinational, one-hot or zero)
//   w, select_register, s    register-file write enable / index / data
//   lock_active              high while the port is held in LOCKED
//   prot_err                 one-cycle pulse on a blocked write to index 0
//
// Optional feature macro: REGFILE_WR_PROTECT_EN
//   Defined: a transfer to index 0 completes its handshake but is not
//   forwarded to the register file; prot_err pulses instead.
//   Undefined: index 0 is an ordinary index and prot_err is tied low.

module regfile_wr_arbiter #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic          req2_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req1_addr,
    input  logic [AW-1:0] req2_addr,
    input  logic [N-1:0]  req0_data,
    input  logic [N-1:0]  req1_data,
    input  logic [N-1:0]  req2_data,
    input  logic          req0_lock,
    input  logic          req1_lock,
    input  logic          req2_lock,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          req2_ready,
    output logic          w,
    output logic [AW-1:0] select_register,
    output logic [N-1:0]  s,
    output logic          lock_active,
    output logic          prot_err
);

    typedef enum logic {FREE, LOCKED} state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    owner, owner_n;
    logic [2:0]    cnt, cnt_n;

    logic [2:0]    valid, lock, ready;
    logic          gnt_any;
    logic [1:0]    gnt, idx;
    logic [AW-1:0] gaddr;
    logic [N-1:0]  gdata;

    assign valid = {req2_valid, req1_valid, req0_valid};
    assign lock  = {req2_lock, req1_lock, req0_lock};
    assign {req2_ready, req1_ready, req0_ready} = ready;
    assign lock_active = (state == LOCKED);

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int unsigned k);
        int unsigned v;
        v = (int'(p) + k) % 3;
        return v[1:0];
    endfunction

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        gnt_any = 1'b0;
        gnt     = '0;
        idx     = '0;
        ready   = '0;
        if (!stall) begin
            case (state)
                FREE: begin
                    for (int unsigned k = 1; k <= 3; k++) begin
                        idx = rr_idx(ptr, k);
                        if (!gnt_any && valid[idx]) begin
                            gnt_any = 1'b1;
                            gnt     = idx;
                        end
                    end
                    if (gnt_any) begin
                        ptr_n = gnt;
                        if (lock[gnt]) begin
                            state_n = LOCKED;
                            owner_n = gnt;
                            // The entry grant is the first of at most eight.
                            cnt_n   = 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (valid[owner]) begin
                        gnt_any = 1'b1;
                        gnt     = owner;
                        if (!lock[owner]) begin
                            state_n = FREE;
                        end else if (cnt == 3'd7) begin
                            // Starvation cap: hand priority to the others.
                            state_n = FREE;
                            ptr_n   = owner;
                        end else begin
                            cnt_n = cnt + 3'd1;
                        end
                    end else begin
                        state_n = FREE;
                    end
                end
                default: state_n = FREE;
            endcase
        end
        if (gnt_any) ready[gnt] = 1'b1;
    end

    always_comb begin
        case (gnt)
            2'd1:    begin gaddr = req1_addr; gdata = req1_data; end
            2'd2:    begin gaddr = req2_addr; gdata = req2_data; end
            default: begin gaddr = req0_addr; gdata = req0_data; end
        endcase
    end

`ifdef REGFILE_WR_PROTECT_EN
    logic prot_q;
    assign prot_err = prot_q;
`else
    assign prot_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FREE;
            ptr             <= 2'd2;
            owner           <= '0;
            cnt             <= '0;
            w               <= 1'b0;
            select_register <= '0;
            s               <= '0;
`ifdef REGFILE_WR_PROTECT_EN
            prot_q          <= 1'b0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            w     <= 1'b0;
`ifdef REGFILE_WR_PROTECT_EN
            prot_q <= 1'b0;
            if (gnt_any) begin
                if (gaddr == '0) begin
                    prot_q <= 1'b1;
                end else begin
                    w               <= 1'b1;
                    select_register <= gaddr;
                    s               <= gdata;
                end
            end
`else
            if (gnt_any) begin
                w               <= 1'b1;
                select_register <= gaddr;
                s               <= gdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: round-robin order, continuous
// single requester, burst lock with 8-grant cap, stall, reset mid-grant,
// and the index-0 write (behaviour depends on REGFILE_WR_PROTECT_EN).

module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        req0_valid, req1_valid, req2_valid;
  logic [3:0]  req0_addr, req1_addr, req2_addr;
  logic [15:0] req0_data, req1_data, req2_data;
  logic        req0_lock, req1_lock, req2_lock;
  logic        req0_ready, req1_ready, req2_ready;
  logic        w, lock_active, prot_err;
  logic [3:0]  select_register;
  logic [15:0] s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.N(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req1_valid(req1_valid), .req2_valid(req2_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr), .req2_addr(req2_addr),
    .req0_data(req0_data), .req1_data(req1_data), .req2_data(req2_data),
    .req0_lock(req0_lock), .req1_lock(req1_lock), .req2_lock(req2_lock),
    .req0_ready(req0_ready), .req1_ready(req1_ready), .req2_ready(req2_ready),
    .w(w), .select_register(select_register), .s(s),
    .lock_active(lock_active), .prot_err(prot_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    req0_valid = 0; req1_valid = 0; req2_valid = 0;
    req0_addr = 0; req1_addr = 0; req2_addr = 0;
    req0_data = 0; req1_data = 0; req2_data = 0;
    req0_lock = 0; req1_lock = 0; req2_lock = 0;
    tick; tick;
    checks++; if (w !== 1'b0) begin failures++; $error("FAIL rst_w observed=%0h expected=0", w); end
    checks++; if (select_register !== 4'h0) begin failures++; $error("FAIL rst_sel observed=%0h expected=0", select_register); end
    checks++; if (s !== 16'h0000) begin failures++; $error("FAIL rst_s observed=%0h expected=0", s); end
    checks++; if (prot_err !== 1'b0) begin failures++; $error("FAIL rst_prot observed=%0h expected=0", prot_err); end
    checks++; if (lock_active !== 1'b0) begin failures++; $error("FAIL rst_lock observed=%0h expected=0", lock_active); end
    rst = 1'b0;

    req0_valid = 1; req0_addr = 4'd3; req0_data = 16'h0011;
    req1_valid = 1; req1_addr = 4'd5; req1_data = 16'h0022;
    req2_valid = 1; req2_addr = 4'd7; req2_data = 16'h0033;
    settle;
    checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b001) begin failures++; $error("FAIL rr_rdy0 observed=%0h expected=1", {req2_ready, req1_ready, req0_ready}); end
    tick;
    checks++; if (w !== 1'b1) begin failures++; $error("FAIL rr_w0 observed=%0h expected=1", w); end
    checks++; if (select_register !== 4'd3) begin failures++; $error("FAIL rr_sel0 observed=%0h expected=3", select_register); end
    checks++; if (s !== 16'h0011) begin failures++; $error("FAIL rr_s0 observed=%0h expected=11", s); end
    req0_valid = 0; settle;
    checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b010) begin failures++; $error("FAIL rr_rdy1 observed=%0h expected=2", {req2_ready, req1_ready, req0_ready}); end
    tick;
    checks++; if (select_register !== 4'd5) begin failures++; $error("FAIL rr_sel1 observed=%0h expected=5", select_register); end
    checks++; if (s !== 16'h0022) begin failures++; $error("FAIL rr_s1 observed=%0h expected=22", s); end
    req1_valid = 0; settle;
    checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b100) begin failures++; $error("FAIL rr_rdy2 observed=%0h expected=4", {req2_ready, req1_ready, req0_ready}); end
    tick;
    checks++; if (w !== 1'b1) begin failures++; $error("FAIL rr_w2 observed=%0h expected=1", w); end
    checks++; if (select_register !== 4'd7) begin failures++; $error("FAIL rr_sel2 observed=%0h expected=7", select_register); end
    checks++; if (s !== 16'h0033) begin failures++; $error("FAIL rr_s2 observed=%0h expected=33", s); end
    req2_valid = 0;
    tick;
    checks++; if (w !== 1'b0) begin failures++; $error("FAIL rr_idle_w observed=%0h expected=0", w); end
    checks++; if (select_register !== 4'd7) begin failures++; $error("FAIL rr_idle_hold observed=%0h expected=7", select_register); end

    req1_valid = 1; req1_addr = 4'd9; req1_data = 16'hBEEF;
    for (int unsigned i = 0; i < 4; i++) begin
      settle;
      checks++; if (req1_ready !== 1'b1) begin failures++; $error("FAIL cont_rdy1 observed=%0h expected=1", req1_ready); end
      tick;
      checks++; if (w !== 1'b1) begin failures++; $error("FAIL cont_w observed=%0h expected=1", w); end
      checks++; if (select_register !== 4'd9) begin failures++; $error("FAIL cont_sel observed=%0h expected=9", select_register); end
    end
    req1_valid = 0;
    tick;
    checks++; if (w !== 1'b0) begin failures++; $error("FAIL cont_end_w observed=%0h expected=0", w); end

    req2_valid = 1; req2_addr = 4'd2; req2_lock = 1; req2_data = 16'hA000;
    req0_valid = 1; req0_addr = 4'd6; req0_data = 16'h0600;
    for (int unsigned i = 0; i < 8; i++) begin
      settle;
      checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b100) begin failures++; $error("FAIL lk_rdy observed=%0h expected=4", {req2_ready, req1_ready, req0_ready}); end
      tick;
      checks++; if (s !== 16'hA000 + 16'(i)) begin failures++; $error("FAIL lk_s observed=%0h expected=%0h", s, 16'hA000 + 16'(i)); end
      checks++; if (lock_active !== ((i < 7) ? 1'b1 : 1'b0)) begin failures++; $error("FAIL lk_active observed=%0h expected=%0h", lock_active, (i < 7) ? 1'b1 : 1'b0); end
      req2_data = 16'hA000 + 16'(i + 1);
    end
    settle;
    checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b001) begin failures++; $error("FAIL lk_cap_rdy observed=%0h expected=1", {req2_ready, req1_ready, req0_ready}); end
    tick;
    checks++; if (select_register !== 4'd6) begin failures++; $error("FAIL lk_r0_sel observed=%0h expected=6", select_register); end
    checks++; if (s !== 16'h0600) begin failures++; $error("FAIL lk_r0_s observed=%0h expected=600", s); end
    req0_valid = 0; req2_lock = 0; settle;
    checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b100) begin failures++; $error("FAIL lk_resume_rdy observed=%0h expected=4", {req2_ready, req1_ready, req0_ready}); end
    tick;
    checks++; if (s !== 16'hA008) begin failures++; $error("FAIL lk_resume_s observed=%0h expected=a008", s); end
    checks++; if (lock_active !== 1'b0) begin failures++; $error("FAIL lk_resume_free observed=%0h expected=0", lock_active); end
    req2_valid = 0;

    stall = 1; req0_valid = 1; req0_addr = 4'd4; req0_data = 16'h1234;
    for (int unsigned i = 0; i < 3; i++) begin
      settle;
      checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b000) begin failures++; $error("FAIL st_rdy observed=%0h expected=0", {req2_ready, req1_ready, req0_ready}); end
      tick;
      checks++; if (w !== 1'b0) begin failures++; $error("FAIL st_w observed=%0h expected=0", w); end
    end
    stall = 0; settle;
    checks++; if (req0_ready !== 1'b1) begin failures++; $error("FAIL st_rel_rdy observed=%0h expected=1", req0_ready); end
    tick;
    checks++; if (w !== 1'b1) begin failures++; $error("FAIL st_w_after observed=%0h expected=1", w); end
    checks++; if (select_register !== 4'd4) begin failures++; $error("FAIL st_sel observed=%0h expected=4", select_register); end
    checks++; if (s !== 16'h1234) begin failures++; $error("FAIL st_s observed=%0h expected=1234", s); end
    req0_valid = 0;

    req0_valid = 1; req0_addr = 4'hA; req0_data = 16'h5555;
    req1_valid = 1; req1_addr = 4'hB; req1_data = 16'h6666;
    rst = 1;
    tick;
    checks++; if (w !== 1'b0) begin failures++; $error("FAIL rg_w observed=%0h expected=0", w); end
    checks++; if (select_register !== 4'h0) begin failures++; $error("FAIL rg_sel observed=%0h expected=0", select_register); end
    checks++; if (s !== 16'h0000) begin failures++; $error("FAIL rg_s observed=%0h expected=0", s); end
    rst = 0; settle;
    checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'b001) begin failures++; $error("FAIL rg_rdy observed=%0h expected=1", {req2_ready, req1_ready, req0_ready}); end
    tick;
    checks++; if (select_register !== 4'hA) begin failures++; $error("FAIL rg_first_sel observed=%0h expected=a", select_register); end
    req0_valid = 0; req1_valid = 0;
    tick;

    req0_valid = 1; req0_addr = 4'h0; req0_data = 16'h00FF; settle;
    checks++; if (req0_ready !== 1'b1) begin failures++; $error("FAIL z_rdy observed=%0h expected=1", req0_ready); end
    tick;
`ifdef REGFILE_WR_PROTECT_EN
    checks++; if (w !== 1'b0) begin failures++; $error("FAIL z_w observed=%0h expected=0", w); end
    checks++; if (prot_err !== 1'b1) begin failures++; $error("FAIL z_prot observed=%0h expected=1", prot_err); end
`else
    checks++; if (w !== 1'b1) begin failures++; $error("FAIL z_w observed=%0h expected=1", w); end
    checks++; if (select_register !== 4'h0) begin failures++; $error("FAIL z_sel observed=%0h expected=0", select_register); end
    checks++; if (s !== 16'h00FF) begin failures++; $error("FAIL z_s observed=%0h expected=ff", s); end
    checks++; if (prot_err !== 1'b0) begin failures++; $error("FAIL z_prot observed=%0h expected=0", prot_err); end
`endif
    req0_valid = 0;

    req2_valid = 1; req2_addr = 4'hF; req2_data = 16'h0F0F;
    tick;
    checks++; if (prot_err !== 1'b0) begin failures++; $error("FAIL f_prot_clr observed=%0h expected=0", prot_err); end
    checks++; if (select_register !== 4'hF) begin failures++; $error("FAIL f_sel observed=%0h expected=f", select_register); end
    checks++; if (s !== 16'h0F0F) begin failures++; $error("FAIL f_s observed=%0h expected=f0f", s); end
    req2_valid = 0;
    tick;
    checks++; if (w !== 1'b0) begin failures++; $error("FAIL f_idle_w observed=%0h expected=0", w); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
